// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared 8-bit memory port (CPU = requester 0, DMA = requester 1).
// One access at a time with fixed latency; writes at or above ROM_BASE never reach memory.
module mem_bus_arbiter #(
  parameter int              AW         = 16,
  parameter int              DW         = 8,
  parameter int              MEM_LAT    = 1,
  parameter logic [AW-1:0]   ROM_BASE   = 16'hF000,
  parameter int              STARVE_MAX = 4
) (
  input  logic          ph2,
  input  logic          reset_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          rom_wr_err,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // DMA wins when it is the only requester or when the CPU has starved it long enough.
  function automatic logic pick_dma(input logic [1:0] r, input logic [SW-1:0] s);
    return r[1] & (~r[0] | (s >= STARVE_TOP));
  endfunction

  function automatic logic is_rom_write(input logic w, input logic [AW-1:0] a);
    return w & (a >= ROM_BASE);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          blk_q, blk_d;
  logic [SW-1:0] starve_q, starve_d, starve_arb;

  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          sel_dma;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_blk;

  // Next-state and next-output logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    blk_d       = blk_q;
    starve_arb  = starve_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    rdata_d     = {DW{1'b0}};
    err_d       = 1'b0;
    busy_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {AW{1'b0}};
    mem_wdata_d = {DW{1'b0}};
    sel_dma     = pick_dma(req, starve_q);
    sel_we      = sel_dma ? we[1] : we[0];
    sel_addr    = sel_dma ? addr1 : addr0;
    sel_wdata   = sel_dma ? wdata1 : wdata0;
    sel_blk     = is_rom_write(sel_we, sel_addr);

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d     = S_BUSY;
          cnt_d       = LAT_INIT;
          win_d       = sel_dma;
          we_d        = sel_we;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          blk_d       = sel_blk;
          gnt_d       = sel_dma ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          mem_en_d    = ~sel_blk;
          mem_we_d    = sel_we & ~sel_blk;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_we ? sel_wdata : {DW{1'b0}};
          if (sel_dma) begin
            starve_arb = {SW{1'b0}};
          end else if (req[1] && (starve_q < STARVE_TOP)) begin
            starve_arb = starve_q + SW'(1);
          end else begin
            starve_arb = starve_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        busy_d = 1'b1;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DONE;
          done_d  = win_q ? 2'b10 : 2'b01;
          rdata_d = we_q ? {DW{1'b0}} : mem_rdata;
          err_d   = blk_q;
        end else begin
          cnt_d       = cnt_q - CW'(1);
          mem_en_d    = ~blk_q;
          mem_we_d    = we_q & ~blk_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = we_q ? wdata_q : {DW{1'b0}};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A DMA requester that is not asking has nothing to be starved of.
    starve_d = req[1] ? starve_arb : {SW{1'b0}};
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge ph2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {AW{1'b0}};
      wdata_q     <= {DW{1'b0}};
      blk_q       <= 1'b0;
      starve_q    <= {SW{1'b0}};
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      rdata_q     <= {DW{1'b0}};
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      blk_q       <= blk_d;
      starve_q    <= starve_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign rom_wr_err = err_q;
  assign busy       = busy_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance A uses MEM_LAT=1, instance B uses MEM_LAT=3.
// A phase-based transaction model is compared every cycle; directed literals pin key points.
module tb_mem_bus_arbiter;

  logic ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  logic        reset_n [2];
  logic [1:0]  req [2];
  logic [1:0]  we [2];
  logic [15:0] addr0 [2];
  logic [15:0] addr1 [2];
  logic [7:0]  wdata0 [2];
  logic [7:0]  wdata1 [2];
  logic [1:0]  gnt [2];
  logic [1:0]  done [2];
  logic [7:0]  rdata [2];
  logic        rom_wr_err [2];
  logic        busy [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [15:0] mem_addr [2];
  logic [7:0]  mem_wdata [2];
  logic [7:0]  mem_rdata [2];

  logic [7:0] mem [2][65536];
  logic [7:0] ref_mem [2][65536];

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.MEM_LAT(1)) u_a (
    .ph2(ph2), .reset_n(reset_n[0]), .req(req[0]), .we(we[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .gnt(gnt[0]), .done(done[0]), .rdata(rdata[0]), .rom_wr_err(rom_wr_err[0]),
    .busy(busy[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_bus_arbiter #(.MEM_LAT(3)) u_b (
    .ph2(ph2), .reset_n(reset_n[1]), .req(req[1]), .we(we[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .gnt(gnt[1]), .done(done[1]), .rdata(rdata[1]), .rom_wr_err(rom_wr_err[1]),
    .busy(busy[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  assign mem_rdata[0] = mem[0][mem_addr[0]];
  assign mem_rdata[1] = mem[1][mem_addr[1]];

  function automatic logic [7:0] init_byte(input int a);
    logic [15:0] aa;
    aa = a[15:0];
    if (aa == 16'h0003) return 8'h22;
    if (aa == 16'hFFFD) return 8'hF0;
    if (aa == 16'hF000) return 8'hA5;
    return aa[7:0] ^ aa[15:8] ^ 8'h5A;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory seen by the DUTs: written mid-cycle while a write strobe is up.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 65536; a++) mem[i][a] = init_byte(a);
    forever begin
      @(negedge ph2);
      for (int i = 0; i < 2; i++)
        if (mem_en[i] === 1'b1 && mem_we[i] === 1'b1) mem[i][mem_addr[i]] = mem_wdata[i];
    end
  end

  // Transaction model: phase 0 = free, k>=1 = k-th cycle since the grant.
  int          phase [2];
  int          win [2];
  bit          mwe [2];
  logic [15:0] maddr [2];
  logic [7:0]  mdata [2];
  int          starve [2];

  task automatic model_step(input int i);
    bit dma;
    if (reset_n[i] !== 1'b1) begin
      phase[i] = 0;
      starve[i] = 0;
    end else begin
      if (phase[i] == 0) begin
        if (req[i] != 2'b00) begin
          dma = req[i][1] && (!req[i][0] || starve[i] >= 4);
          win[i] = dma ? 1 : 0;
          mwe[i] = dma ? we[i][1] : we[i][0];
          maddr[i] = dma ? addr1[i] : addr0[i];
          mdata[i] = dma ? wdata1[i] : wdata0[i];
          if (dma) starve[i] = 0;
          else if (req[i][1]) starve[i] = (starve[i] >= 4) ? 4 : starve[i] + 1;
          phase[i] = 1;
        end
      end else if (phase[i] == lat_of(i) + 1) begin
        if (mwe[i] && maddr[i] < 16'hF000) ref_mem[i][maddr[i]] = mdata[i];
        phase[i] = 0;
      end else begin
        phase[i]++;
      end
      if (!req[i][1]) starve[i] = 0;
    end
  endtask

  function automatic logic [39:0] expect_out(input int i);
    logic [1:0] g, dn;
    logic [7:0] rd, wd;
    logic er, bz, en, mw;
    logic [15:0] ma;
    bit blk;
    int k, l;
    g = 2'b00; dn = 2'b00; rd = 8'h00; wd = 8'h00;
    er = 1'b0; bz = 1'b0; en = 1'b0; mw = 1'b0; ma = 16'h0000;
    k = phase[i];
    l = lat_of(i);
    if (reset_n[i] === 1'b1 && k >= 1) begin
      blk = mwe[i] && (maddr[i] >= 16'hF000);
      bz = 1'b1;
      if (k == 1) g = (win[i] == 1) ? 2'b10 : 2'b01;
      if (k <= l) begin
        en = !blk;
        mw = en && mwe[i];
        ma = maddr[i];
        wd = mwe[i] ? mdata[i] : 8'h00;
      end
      if (k == l + 1) begin
        dn = (win[i] == 1) ? 2'b10 : 2'b01;
        rd = mwe[i] ? 8'h00 : ref_mem[i][maddr[i]];
        er = blk;
      end
    end
    return {g, dn, rd, er, bz, en, mw, ma, wd};
  endfunction

  function automatic logic [39:0] pack_out(input int i);
    return {gnt[i], done[i], rdata[i], rom_wr_err[i], busy[i], mem_en[i], mem_we[i],
            mem_addr[i], mem_wdata[i]};
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 65536; a++) ref_mem[i][a] = init_byte(a);
      phase[i] = 0;
      starve[i] = 0;
    end
    forever begin
      @(posedge ph2);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge ph2);
      check("model_a", {24'h0, pack_out(0)}, {24'h0, expect_out(0)});
      check("model_b", {24'h0, pack_out(1)}, {24'h0, expect_out(1)});
    end
  end

  logic [1:0]  tr_gnt [8];
  logic [1:0]  tr_done [8];
  logic [7:0]  tr_rdata [8];
  logic [15:0] tr_addr [8];
  logic        tr_en [8];
  logic        tr_we [8];
  logic        tr_err [8];
  logic        tr_busy [8];

  // One access with a cycle trace; cycle 0 is the cycle req first goes high.
  task automatic access(input int i, input int who, input logic w, input logic [15:0] a,
                        input logic [7:0] d);
    @(posedge ph2);
    #1;
    we[i][who] = w;
    if (who == 0) begin
      addr0[i] = a;
      wdata0[i] = d;
    end else begin
      addr1[i] = a;
      wdata1[i] = d;
    end
    req[i][who] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge ph2);
      tr_gnt[c] = gnt[i];
      tr_done[c] = done[i];
      tr_rdata[c] = rdata[i];
      tr_addr[c] = mem_addr[i];
      tr_en[c] = mem_en[i];
      tr_we[c] = mem_we[i];
      tr_err[c] = rom_wr_err[i];
      tr_busy[c] = busy[i];
      if (gnt[i][who]) req[i][who] = 1'b0;
    end
    req[i][who] = 1'b0;
  endtask

  logic [9:0] order;
  int         n;
  int         gap;
  logic [1:0] gseen;

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0;
      req[i] = 2'b00;
      we[i] = 2'b00;
      addr0[i] = 16'h0000;
      addr1[i] = 16'h0000;
      wdata0[i] = 8'h00;
      wdata1[i] = 8'h00;
    end
    repeat (3) @(negedge ph2);
    #1;
    check("reset_out_a", {24'h0, pack_out(0)}, 64'h0);
    check("reset_out_b", {24'h0, pack_out(1)}, 64'h0);
    #1;
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    repeat (2) @(posedge ph2);

    access(0, 0, 1'b0, 16'h0003, 8'h00);
    check("t1_gnt", tr_gnt[1], 2'b01);
    check("t1_en", tr_en[1], 1'b1);
    check("t1_done", tr_done[2], 2'b01);
    check("t1_rdata", tr_rdata[2], 8'h22);
    check("t1_busy", {tr_busy[0], tr_busy[1], tr_busy[2], tr_busy[3]}, 4'b0110);

    access(0, 0, 1'b1, 16'h0123, 8'h00);
    check("t2_we", {tr_we[1], tr_we[2]}, 2'b10);
    check("t2_addr", tr_addr[1], 16'h0123);
    access(0, 0, 1'b0, 16'h0123, 8'hFF);
    check("t2_readback", tr_rdata[2], 8'h00);
    access(0, 1, 1'b1, 16'h0004, 8'd117);
    check("t2_dma_done", tr_done[2], 2'b10);
    access(0, 1, 1'b0, 16'h0004, 8'h00);
    check("t2_dma_readback", tr_rdata[2], 8'd117);

    access(0, 0, 1'b1, 16'hFFFD, 8'h55);
    check("t4_no_en", {tr_en[0], tr_en[1], tr_en[2], tr_en[3]}, 4'b0000);
    check("t4_done", tr_done[2], 2'b01);
    check("t4_err", tr_err[2], 1'b1);
    access(0, 0, 1'b0, 16'hFFFD, 8'h00);
    check("t4_rom_unchanged", tr_rdata[2], 8'hF0);
    check("t4_no_err_read", tr_err[2], 1'b0);

    @(posedge ph2);
    #1;
    addr0[0] = 16'h0010;
    addr1[0] = 16'h0020;
    we[0] = 2'b00;
    req[0] = 2'b11;
    n = 0;
    order = 10'h000;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge ph2);
      if (gnt[0] != 2'b00) begin
        order[n] = gnt[0][1];
        n++;
        if (n == 10) req[0] = 2'b10;
      end
    end
    check("t3_grant_count", n, 10);
    check("t3_grant_order", order, 10'h210);
    gap = 0;
    gseen = 2'b00;
    for (int c = 0; c < 20 && gseen == 2'b00; c++) begin
      @(negedge ph2);
      gap++;
      if (gnt[0] != 2'b00) begin
        gseen = gnt[0];
        req[0] = 2'b00;
      end
    end
    req[0] = 2'b00;
    check("t3_dma_alone_gap", gap, 3);
    check("t3_dma_alone_gnt", gseen, 2'b10);
    repeat (5) @(negedge ph2);

    access(1, 0, 1'b0, 16'hF000, 8'h00);
    check("t6_en", {tr_en[0], tr_en[1], tr_en[2], tr_en[3], tr_en[4], tr_en[5]}, 6'b011100);
    check("t6_no_early_done", tr_done[3], 2'b00);
    check("t6_done", tr_done[4], 2'b01);
    check("t6_rdata", tr_rdata[4], 8'hA5);

    @(posedge ph2);
    #1;
    addr0[1] = 16'h0010;
    we[1] = 2'b00;
    req[1] = 2'b01;
    repeat (3) @(negedge ph2);
    check("t5_en_before_reset", mem_en[1], 1'b1);
    #2;
    reset_n[1] = 1'b0;
    req[1] = 2'b10;
    addr1[1] = 16'h0030;
    #1;
    check("t5_outputs_zero", {24'h0, pack_out(1)}, 64'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge ph2);
      check("t5_no_done", done[1], 2'b00);
    end
    #2;
    reset_n[1] = 1'b1;
    @(negedge ph2);
    check("t5_dma_first", gnt[1], 2'b10);
    req[1] = 2'b00;
    repeat (6) @(negedge ph2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
